// File: rtl/aes_sbox_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_sched
// Purpose  : Time-multiplexed SubBytes/SubWord engine that shares LANES S-box
//            lookups between the round datapath (128-bit) and the key
//            expansion (32-bit).
// Option   : define AES_SBOX_SCHED_RR_EN for round-robin arbitration
//            (default build uses fixed priority set by KEY_PRIO).
// Revision : 1.0
// ============================================================================

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse computed as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv_w;

  assign inv_w = gf_inv(in_i);
  assign out_o = inv_w
               ^ {inv_w[6:0], inv_w[7]}
               ^ {inv_w[5:0], inv_w[7:6]}
               ^ {inv_w[4:0], inv_w[7:5]}
               ^ {inv_w[3:0], inv_w[7:4]}
               ^ 8'h63;

endmodule

module aes_sbox_sched #(
  parameter int LANES    = 4,
  parameter bit KEY_PRIO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_ack,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_ack,
  output logic [31:0]  kw_out,
  output logic         busy
);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_sbox_sched: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int         ST_BEATS = 16 / LANES;
  localparam int         KW_BEATS = (LANES >= 4) ? 1 : (4 / LANES);
  localparam logic [3:0] ST_LAST  = 4'(ST_BEATS - 1);
  localparam logic [3:0] KW_LAST  = 4'(KW_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e         state_q;
  logic [127:0]   work_q;
  logic           key_job_q;
  logic [3:0]     beat_q;
  logic [127:0]   st_out_q;
  logic [31:0]    kw_out_q;
  logic           st_ack_q;
  logic           kw_ack_q;

  logic [127:0]   st_out_d;
  logic [31:0]    kw_out_d;
  logic           prio_key_w;
  logic           grant_key_w;
  logic           last_beat_w;

  logic [7:0]     lane_in_w  [LANES];
  logic [7:0]     lane_out_w [LANES];
  logic [3:0]     lane_idx_w [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx_w[l] = 4'((32'(beat_q) * LANES) + l);
    assign lane_in_w[l]  = work_q[{lane_idx_w[l], 3'b000} +: 8];
    aes_sbox u_sbox (
      .in_i  (lane_in_w[l]),
      .out_o (lane_out_w[l])
    );
  end

  // Key jobs only keep lanes that land on bytes 0..3 of the key word.
  always_comb begin
    st_out_d = st_out_q;
    kw_out_d = kw_out_q;
    for (int l = 0; l < LANES; l++) begin
      if (key_job_q) begin
        if (lane_idx_w[l] < 4'd4) begin
          kw_out_d[{lane_idx_w[l][1:0], 3'b000} +: 8] = lane_out_w[l];
        end
      end else begin
        st_out_d[{lane_idx_w[l], 3'b000} +: 8] = lane_out_w[l];
      end
    end
  end

`ifdef AES_SBOX_SCHED_RR_EN
  logic last_key_q;

  assign prio_key_w = ~last_key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_key_q <= 1'b0;
    end else if (state_q == S_IDLE && (st_req || kw_req)) begin
      last_key_q <= grant_key_w;
    end
  end
`else
  assign prio_key_w = KEY_PRIO;
`endif

  assign grant_key_w = kw_req & (~st_req | prio_key_w);
  assign last_beat_w = (beat_q == (key_job_q ? KW_LAST : ST_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      key_job_q <= 1'b0;
      beat_q    <= 4'd0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_ack_q  <= 1'b0;
      kw_ack_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (st_req || kw_req) begin
            key_job_q <= grant_key_w;
            work_q    <= grant_key_w ? {96'd0, kw_in} : st_in;
            beat_q    <= 4'd0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          st_out_q <= st_out_d;
          kw_out_q <= kw_out_d;
          if (last_beat_w) begin
            state_q  <= S_ACK;
            st_ack_q <= ~key_job_q;
            kw_ack_q <= key_job_q;
          end else begin
            beat_q <= beat_q + 4'd1;
          end
        end
        S_ACK: begin
          st_ack_q <= 1'b0;
          kw_ack_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign st_ack = st_ack_q;
  assign kw_ack = kw_ack_q;
  assign st_out = st_out_q;
  assign kw_out = kw_out_q;
  assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sbox_sched
// Purpose  : Directed bench for aes_sbox_sched with four instances
//            (LANES=4/1/16 with KEY_PRIO=1, LANES=4 with KEY_PRIO=0).
// Revision : 1.0
// ============================================================================

module tb_aes_sbox_sched;

  localparam int ND = 4;

  localparam logic [127:0] V_ST = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] R_ST = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [31:0]  V_KW = 32'h00010203;
  localparam logic [31:0]  R_KW = 32'h637c777b;
  localparam logic [127:0] F_ST = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] F_SR = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [31:0]  F_KW = 32'hcf4f3c09;
  localparam logic [31:0]  F_KR = 32'h8a84eb01;

`ifdef AES_SBOX_SCHED_RR_EN
  localparam bit P0_KEY_FIRST = 1'b1;
`else
  localparam bit P0_KEY_FIRST = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic [127:0]          st_in;
  logic [31:0]           kw_in;
  logic [ND-1:0]         st_req;
  logic [ND-1:0]         kw_req;
  logic [ND-1:0]         st_ack;
  logic [ND-1:0]         kw_ack;
  logic [ND-1:0]         busy;
  logic [ND-1:0][127:0]  st_out;
  logic [ND-1:0][31:0]   kw_out;

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    aes_sbox_sched #(
      .LANES    (g == 1 ? 1 : (g == 2 ? 16 : 4)),
      .KEY_PRIO (g == 3 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .st_req (st_req[g]),
      .st_in  (st_in),
      .st_ack (st_ack[g]),
      .st_out (st_out[g]),
      .kw_req (kw_req[g]),
      .kw_in  (kw_in),
      .kw_ack (kw_ack[g]),
      .kw_out (kw_out[g]),
      .busy   (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges until the selected ack(s) rise; bounded at 40 edges.
  task automatic wait_ack(input int d, input bit want_st, input bit want_kw, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!((want_st && st_ack[d]) || (want_kw && kw_ack[d])) && n < 40);
  endtask

  task automatic run_job(input int d, input bit key, input logic [127:0] din,
                         input logic [127:0] exp, input int lat, input string tag);
    int n;
    @(negedge clk);
    if (key) begin
      kw_in     = din[31:0];
      kw_req[d] = 1'b1;
    end else begin
      st_in     = din;
      st_req[d] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_busy"}, 128'(busy[d]), 128'd1);
    wait_ack(d, !key, key, n);
    if (key) kw_req[d] = 1'b0;
    else     st_req[d] = 1'b0;
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_data"}, key ? {96'd0, kw_out[d]} : st_out[d], exp);
    chk({tag, "_other_ack"}, 128'(key ? st_ack[d] : kw_ack[d]), 128'd0);
    @(posedge clk);
    #1;
    chk({tag, "_ack_fall"}, 128'(key ? kw_ack[d] : st_ack[d]), 128'd0);
    chk({tag, "_idle"}, 128'(busy[d]), 128'd0);
  endtask

  // Both requests in the same cycle; loser granted on the first IDLE edge after the winner's ack.
  task automatic tie_job(input int d, input bit key_first, input string tag);
    int n;
    @(negedge clk);
    st_in     = F_ST;
    kw_in     = F_KW;
    st_req[d] = 1'b1;
    kw_req[d] = 1'b1;
    @(posedge clk);
    wait_ack(d, 1'b1, 1'b1, n);
    chk({tag, "_first_kw"}, 128'(kw_ack[d]), 128'(key_first));
    chk({tag, "_first_st"}, 128'(st_ack[d]), 128'(!key_first));
    chk({tag, "_first_lat"}, 128'(n), key_first ? 128'd1 : 128'd4);
    if (key_first) kw_req[d] = 1'b0;
    else           st_req[d] = 1'b0;
    wait_ack(d, key_first, !key_first, n);
    chk({tag, "_second_lat"}, 128'(n), key_first ? 128'd6 : 128'd3);
    if (key_first) st_req[d] = 1'b0;
    else           kw_req[d] = 1'b0;
    chk({tag, "_st_data"}, st_out[d], F_SR);
    chk({tag, "_kw_data"}, {96'd0, kw_out[d]}, {96'd0, F_KR});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    bit  seen;
    bit  exp_key;
    rst    = 1'b1;
    st_req = '0;
    kw_req = '0;
    st_in  = '0;
    kw_in  = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst_st_ack", 128'(st_ack[d]), 128'd0);
      chk("rst_kw_ack", 128'(kw_ack[d]), 128'd0);
      chk("rst_st_out", st_out[d], 128'd0);
      chk("rst_kw_out", {96'd0, kw_out[d]}, 128'd0);
      chk("rst_busy", 128'(busy[d]), 128'd0);
    end
    rst = 1'b0;

    run_job(0, 1'b0, V_ST, R_ST, 4, "l4_st");
    run_job(0, 1'b1, {96'd0, V_KW}, {96'd0, R_KW}, 1, "l4_kw");
    chk("l4_st_hold", st_out[0], R_ST);
    run_job(0, 1'b0, F_ST, F_SR, 4, "l4_st_fips");
    run_job(0, 1'b1, {96'd0, F_KW}, {96'd0, F_KR}, 1, "l4_kw_fips");
    chk("l4_st_hold2", st_out[0], F_SR);
    run_job(1, 1'b0, V_ST, R_ST, 16, "l1_st");
    run_job(1, 1'b1, {96'd0, V_KW}, {96'd0, R_KW}, 4, "l1_kw");
    run_job(2, 1'b0, V_ST, R_ST, 1, "l16_st");
    run_job(2, 1'b1, {96'd0, V_KW}, {96'd0, R_KW}, 1, "l16_kw");

    // Abort a LANES=4 state job while beat 2 is pending.
    @(negedge clk);
    st_in     = V_ST;
    st_req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_st_out", st_out[0], 128'd0);
    chk("abort_kw_out", {96'd0, kw_out[0]}, 128'd0);
    chk("abort_busy", 128'(busy[0]), 128'd0);
    chk("abort_st_ack", 128'(st_ack[0]), 128'd0);
    st_req[0] = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | st_ack[0] | busy[0];
    end
    chk("abort_no_ack", 128'(seen), 128'd0);
    run_job(0, 1'b0, F_ST, F_SR, 4, "recover_st");

    tie_job(0, 1'b1, "tie_p1");
    tie_job(3, P0_KEY_FIRST, "tie_p0");

`ifdef AES_SBOX_SCHED_RR_EN
    @(negedge clk);
    st_in     = F_ST;
    kw_in     = F_KW;
    st_req[0] = 1'b1;
    kw_req[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_key = (j % 2 == 0);
      wait_ack(0, 1'b1, 1'b1, n);
      chk("rr_order", 128'(kw_ack[0]), 128'(exp_key));
      chk("rr_lat", 128'(n), exp_key ? 128'd2 : 128'd5);
      if (j >= 2) begin
        if (exp_key) kw_req[0] = 1'b0;
        else         st_req[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rr_idle_gap", 128'(busy[0]), 128'd0);
    end
    chk("rr_st_data", st_out[0], F_SR);
    chk("rr_kw_data", {96'd0, kw_out[0]}, {96'd0, F_KR});
`else
    exp_key = 1'b0;
    n       = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/aes_sbox_sched.md
Name: aes_sbox_sched

Overview:
- Time-multiplexed SubBytes engine built around a small pool of aes_sbox lookup instances (combinational, 8-bit in / 8-bit out).
- Shares those lanes between two requesters:
  - the round datapath, which needs 128-bit SubBytes;
  - the key expansion, which needs 32-bit SubWord.
- Arbitrates between the requesters, sequences lookups over multiple beats, registers the results and acknowledges each job with a one-cycle pulse.

Parameters:
- LANES, 4: number of aes_sbox instances. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- KEY_PRIO, 1: on a tie, 1 means the key channel wins and 0 means the state channel wins. Used only when AES_SBOX_SCHED_RR_EN is undefined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_req  in  1  state SubBytes request; held high until st_ack.
- st_in  in  128  state input; byte i is bits [8i+7:8i].
- st_ack  out  1  one-cycle done pulse for the state job.
- st_out  out  128  SubBytes result; valid while st_ack=1 and held until the next state job's ack.
- kw_req  in  1  key-word SubWord request; held high until kw_ack.
- kw_in  in  32  key word input; same byte order as st_in.
- kw_ack  out  1  one-cycle done pulse for the key job.
- kw_out  out  32  SubWord result; held until the next key job's ack.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, while rst=1):
  - st_ack=0, kw_ack=0, st_out=0, kw_out=0, busy=0.
  - FSM=IDLE, beat counter=0, last-served=state channel.
  - Reset mid-job aborts the job: no ack is issued and outputs return to 0.
- FSM states: IDLE, RUN, ACK.
- IDLE:
  - Samples st_req and kw_req on each edge.
  - If either is high, the winner is granted at that edge (the grant edge).
  - At the grant edge, the winner's input is latched into an internal 128-bit work register (key word zero-extended), job type is recorded, beat counter is cleared, and FSM moves to RUN.
- RUN:
  - Beats per job:
    - state job: B = 16/LANES;
    - key job: B = max(1, 4/LANES).
  - Beat k feeds bytes k*LANES .. k*LANES+LANES-1 through lanes 0..LANES-1.
  - For a key job with LANES>4, only lanes 0..3 carry data. The other lanes carry don't-care values and their results are discarded.
  - Each beat's results are written into the destination register (st_out or kw_out) at that beat's edge.
  - On the edge of the last beat: FSM goes to ACK and the matching ack is set to 1 (registered).
  - Ack therefore rises after the B-th edge following the grant edge. With LANES=4: state ack after 4 edges, key ack after 1 edge.
- Output holding: st_out and kw_out update only during their own job. Partially written bytes are not guaranteed stable before ack; consumers sample only when ack=1.
- ACK:
  - Exactly one cycle. Ack falls at the next edge and FSM returns to IDLE.
  - A requester that still holds req high in IDLE starts a new job. Requesters must drop req on the edge that sees ack unless issuing another job.
  - Minimum spacing between grants is B+2 edges.
- Arbitration:
  - Only evaluated in IDLE.
  - A request that arrives while busy=1 waits; no request is lost.
  - The losing channel is granted at the first IDLE sample after the current job completes.
- Req dropped before ack: illegal. The job still completes and the ack is still issued.
- Both acks are never high in the same cycle.
- The blocks register the ack, so the channel outputs carry no combinational path from inputs.

Optional Feature:
- Macro: AES_SBOX_SCHED_RR_EN.
- Defined: round-robin arbitration. On a tie, the channel not served last wins. The last-served register updates at every grant edge and resets to the state channel, so the first tie after reset goes to the key channel. KEY_PRIO is ignored.
- Undefined: fixed priority per KEY_PRIO. The last-served register is not implemented.

Test Plan:
- LANES=4; st_in=128'h0f0e0d0c0b0a09080706050403020100, st_req pulse-held -> st_ack rises exactly 4 edges after the grant edge, for one cycle; st_out=128'h76abd7fe2b670130c56f6bf27b777c63.
- LANES=4; kw_in=32'h00010203 -> kw_ack after 1 edge; kw_out=32'h637c777b.
- LANES=1 and LANES=16, same vectors as above -> state ack after 16 and 1 edges, key ack after 4 and 1 edges, with identical data results.
- KEY_PRIO=1, RR off; st_req and kw_req rise in the same cycle -> key job acked first. The state job is granted at the first IDLE edge after kw_ack, and both results are correct. Repeat with KEY_PRIO=0 -> order reversed.
- AES_SBOX_SCHED_RR_EN defined; both requests held continuously for 4 jobs -> grant order key, state, key, state; busy low only in the IDLE cycles between jobs.
- Assert rst during beat 2 of a LANES=4 state job -> immediately st_out=0, busy=0, no st_ack. After release, a new request completes normally with correct data.
